seq_mult4_ctrl: RTL

Sequential 4×4 unsigned shift-and-add multiplier controller that time-multiplexes a single `four_bit_adder` instance over four iterations to form an 8-bit product. It accepts operand pairs through a valid/ready handshake and returns the product through a second valid/ready handshake. The block is the standard way to obtain multiplication in the datapath without replicating adders.

---
 rtl/mult_ctrl_pkg.sv | 16 +
 rtl/four_bit_adder.sv | 16 +
 rtl/seq_mult4_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential 4x4 multiplier controller.
//   state_t    : controller state encoding (IDLE/RUN/DONE; 2'b11 is unused)
//   MULT_W     : operand width, fixed by the shared four-bit adder
//   MULT_STEPS : shift-and-add iterations per product
package mult_ctrl_pkg;

  localparam int MULT_W     = 4;
  localparam int MULT_STEPS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/four_bit_adder.sv
// Four-bit ripple adder with carry in/out.
//   i_a, i_b : 4-bit addends
//   i_cin    : carry in
//   o_sum    : 4-bit sum
//   o_cout   : carry out
module four_bit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

endmodule

// File: rtl/seq_mult4_ctrl.sv
// Sequential 4x4 unsigned shift-and-add multiplier. A single four_bit_adder
// is reused over four iterations to build an 8-bit product.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_a (multiplicand), in_b (multiplier)
//   out_valid/out_ready : result handshake, product = in_a * in_b
//   busy                : high while an operation is in RUN or DONE
module seq_mult4_ctrl
  import mult_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MULT_W-1:0] in_a,
  input  logic [MULT_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*MULT_W-1:0] product,
  output logic              busy
);

  localparam logic [1:0] LAST_CNT = 2'(MULT_STEPS - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [MULT_W-1:0] r_m;
  logic [MULT_W-1:0] r_acc;
  logic [MULT_W-1:0] r_q;
  logic [1:0]        r_cnt;

  logic [MULT_W-1:0] w_addend;
  logic [MULT_W-1:0] w_sum;
  logic              w_cout;
  logic              w_accept;
  logic              w_step;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;

  // Add the multiplicand only when the current multiplier bit is set.
  assign w_addend = r_q[0] ? r_m : '0;

  four_bit_adder u_adder (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        w_busy = 1'b1;
        if (r_cnt == LAST_CNT) w_next_state = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;  // unused 2'b11 recovers to IDLE
    endcase
  end

  // Outputs are forced low while reset is held so nothing handshakes during it.
  assign in_ready  = w_in_ready  & rst_n;
  assign out_valid = w_out_valid & rst_n;
  assign busy      = w_busy      & rst_n;
  assign product   = {r_acc, r_q};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_m   <= in_a;
        r_q   <= in_b;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_step) begin
        // Shift the 5-bit partial sum into the accumulator; the consumed
        // multiplier bit falls off the bottom of Q.
        {r_acc, r_q} <= {w_cout, w_sum, r_q[MULT_W-1:1]};
        r_cnt        <= r_cnt + 2'd1;
      end
    end
  end

endmodule
